// File: rtl/prod_accum_pkg.sv
// prod_accum_pkg
//   Shared definitions for the product accumulator slice: default data
//   widths (PROD_W matches the out width of shift_add_multi_4bit) and the
//   FSM state encodings used by prod_accum.
package prod_accum_pkg;

    // Default widths; the module parameters take their defaults from these.
    localparam int unsigned DEF_PROD_W = 8;
    localparam int unsigned DEF_ACC_W  = 11;
    localparam int unsigned DEF_CNT_W  = 4;

    // Controller state encodings.
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

endpackage

// File: rtl/prod_accum_sat_add.sv
// sat_add
//   Unsigned saturating adder: y = min(a + b, 2^A_W - 1).
//   Purely combinational.
// Ports:
//   a   [A_W-1:0]  accumulator operand
//   b   [B_W-1:0]  addend, zero-extended to A_W+1 bits (requires B_W <= A_W)
//   y   [A_W-1:0]  saturated sum
//   sat            high when the true sum did not fit and y was clamped
module sat_add
    import prod_accum_pkg::*;
#(
    parameter int unsigned A_W = DEF_ACC_W,
    parameter int unsigned B_W = DEF_PROD_W
) (
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic [A_W-1:0] y,
    output logic           sat
);

    logic [A_W:0] sum_ext;

    always_comb begin
        sum_ext = {1'b0, a} + {{(A_W + 1 - B_W){1'b0}}, b};
        // The carry out of the A_W-bit field is exactly the overflow condition.
        sat     = sum_ext[A_W];
        y       = sat ? '1 : sum_ext[A_W-1:0];
    end

endmodule

// File: rtl/prod_accum.sv
// prod_accum
//   Accumulates a programmed number of unsigned products into a saturating
//   sum (MAC back end for the shift-add multiplier). A start/len command
//   opens a run; each in_valid cycle in ACCUM adds one term. When the last
//   term is taken the block spends exactly one cycle in DONE, pulsing
//   sum_valid, and accepts a new command in that same cycle.
// Ports:
//   clk        rising-edge clock
//   n_rst      asynchronous active-low reset
//   start      command strobe, honoured only in IDLE or DONE
//   len        number of terms to accumulate, sampled with start
//   in_valid   prod is a valid term this cycle
//   prod       unsigned product input
//   busy       high while accumulating
//   sum_valid  one-cycle completion pulse
//   sum        accumulator register, held until the next accepted start
//   ovf        sticky saturation flag, cleared by an accepted start
module prod_accum
    import prod_accum_pkg::*;
#(
    parameter int unsigned PROD_W = DEF_PROD_W,
    parameter int unsigned ACC_W  = DEF_ACC_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              in_valid,
    input  logic [PROD_W-1:0] prod,
    output logic              busy,
    output logic              sum_valid,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    logic [1:0]       state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf_q;

    logic [ACC_W-1:0] acc_next;
    logic             sat_hit;

    sat_add #(
        .A_W (ACC_W),
        .B_W (PROD_W)
    ) u_sat_add (
        .a   (acc),
        .b   (prod),
        .y   (acc_next),
        .sat (sat_hit)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else begin
            case (state)
                // DONE shares IDLE's command handling so back-to-back
                // commands need no idle cycle in between.
                IDLE, DONE: begin
                    if (start) begin
                        acc   <= '0;
                        ovf_q <= 1'b0;
                        if (len != '0) begin
                            cnt   <= len;
                            state <= ACCUM;
                        end else begin
                            state <= DONE;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc <= acc_next;
                        cnt <= cnt - 1'b1;
                        if (sat_hit) begin
                            ovf_q <= 1'b1;
                        end
                        if (cnt == CNT_W'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state == ACCUM);
    assign sum_valid = (state == DONE);
    assign sum       = acc;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_prod_accum.sv
// tb_prod_accum
//   Directed bench for prod_accum. Stimulus pushes the hand-computed
//   {ovf, sum} of each run into a queue; a monitor pops and compares on
//   every sum_valid pulse. Inline checks cover reset, busy, latency and
//   pulse width.
module tb_prod_accum;

    localparam int unsigned PROD_W = 8;
    localparam int unsigned ACC_W  = 11;
    localparam int unsigned CNT_W  = 4;

    logic              clk;
    logic              n_rst;
    logic              start;
    logic [CNT_W-1:0]  len;
    logic              in_valid;
    logic [PROD_W-1:0] prod;
    logic              busy;
    logic              sum_valid;
    logic [ACC_W-1:0]  sum;
    logic              ovf;

    prod_accum #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .prod      (prod),
        .busy      (busy),
        .sum_valid (sum_valid),
        .sum       (sum),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int pulses = 0;

    // Expected result per completed run: {ovf, sum}.
    logic [ACC_W:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (n_rst && sum_valid) begin
            logic [ACC_W:0] e;
            pulses++;
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL sb_unexpected: got sum_valid with sum %0d, expected no pulse at %0t",
                         sum, $time);
            end else begin
                e = exp_q.pop_front();
                check("sb_sum", int'(sum), int'(e[ACC_W-1:0]));
                check("sb_ovf", int'(ovf), int'(e[ACC_W]));
            end
        end
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input int l);
        start = 1'b1;
        len   = CNT_W'(l);
        tick();
        start = 1'b0;
    endtask

    task automatic term(input int p);
        in_valid = 1'b1;
        prod     = PROD_W'(p);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        n_rst    = 1'b0;
        start    = 1'b0;
        len      = '0;
        in_valid = 1'b0;
        prod     = '0;

        // Reset
        repeat (2) tick();
        n_rst = 1'b1;
        tick();
        check("rst_busy", int'(busy), 0);
        check("rst_sum_valid", int'(sum_valid), 0);
        check("rst_sum", int'(sum), 0);
        check("rst_ovf", int'(ovf), 0);

        // Basic: 225 + 110 = 335
        exp_q.push_back({1'b0, 11'd335});
        cmd(2);
        check("basic_busy", int'(busy), 1);
        term(225);
        term(110);
        check("basic_latency", int'(sum_valid), 1);
        tick();
        check("basic_pulse_width", int'(sum_valid), 0);
        check("basic_busy_after", int'(busy), 0);
        check("basic_sum_held", int'(sum), 335);

        // Gaps and ignored start: 100 + 50 + 25 = 175
        exp_q.push_back({1'b0, 11'd175});
        cmd(3);
        term(100);
        for (int i = 0; i < 3; i++) begin
            start = (i == 1);
            len   = '0;
            tick();
            check("gap_busy", int'(busy), 1);
        end
        start = 1'b0;
        check("gap_sum_partial", int'(sum), 100);
        term(50);
        term(25);
        check("gap_latency", int'(sum_valid), 1);
        tick();

        // Saturation: 10 x 225 = 2250 clamps to 2047
        exp_q.push_back({1'b1, 11'd2047});
        cmd(10);
        for (int i = 0; i < 9; i++) term(225);
        check("sat_pre_sum", int'(sum), 2025);
        check("sat_pre_ovf", int'(ovf), 0);
        term(225);
        tick();
        check("sat_ovf_held", int'(ovf), 1);

        // New command clears ovf at acceptance
        exp_q.push_back({1'b0, 11'd5});
        cmd(1);
        check("sat_clr_ovf", int'(ovf), 0);
        check("sat_clr_sum", int'(sum), 0);
        term(5);
        tick();

        // len = 0
        exp_q.push_back({1'b0, 11'd0});
        cmd(0);
        check("len0_latency", int'(sum_valid), 1);
        check("len0_busy", int'(busy), 0);
        tick();
        check("len0_pulse_width", int'(sum_valid), 0);

        // Start accepted in DONE: 3 then 9 back to back
        exp_q.push_back({1'b0, 11'd3});
        exp_q.push_back({1'b0, 11'd9});
        cmd(1);
        term(3);
        check("b2b_done", int'(sum_valid), 1);
        cmd(1);
        check("b2b_no_idle", int'(busy), 1);
        term(9);
        check("b2b_latency", int'(sum_valid), 1);
        tick();

        // Reset mid-run aborts, asynchronously
        cmd(4);
        term(60);
        term(70);
        #2;
        n_rst = 1'b0;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_sum", int'(sum), 0);
        check("arst_ovf", int'(ovf), 0);
        check("arst_sum_valid", int'(sum_valid), 0);
        tick();
        #2;
        n_rst = 1'b1;
        tick();
        exp_q.push_back({1'b0, 11'd7});
        cmd(1);
        term(7);
        tick();
        tick();

        check("sb_drained", exp_q.size(), 0);
        check("pulse_count", pulses, 8);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
